// File: rtl/demux1_2.sv
// ============================================================================
// demux1_2 : registered 1-to-2 valid/ready demultiplexer, per-port counters
// Revision : 1.0
// ============================================================================
`default_nettype none

module demux1_2 #(
  parameter int BITS     = 13,
  parameter int CNT_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                sel,
  input  logic [BITS-1:0]     in_data,
  output logic                out0_valid,
  input  logic                out0_ready,
  output logic [BITS-1:0]     out0_data,
  output logic                out1_valid,
  input  logic                out1_ready,
  output logic [BITS-1:0]     out1_data,
  output logic [CNT_BITS-1:0] cnt0,
  output logic [CNT_BITS-1:0] cnt1
);

  logic [1:0]          w_out_ready;
  logic [1:0]          w_valid;
  logic [1:0]          w_free;
  logic [1:0]          w_port_sel;
  logic [BITS-1:0]     w_data [2];
  logic [CNT_BITS-1:0] w_cnt  [2];

  assign w_out_ready = {out1_ready, out0_ready};
  assign w_free      = ~w_valid | w_out_ready;
  assign w_port_sel  = {sel, ~sel};

  // Reset gating keeps upstream from seeing a handshake the slots will ignore.
  assign in_ready = rst_n & (sel ? w_free[1] : w_free[0]);

  generate
    for (genvar n = 0; n < 2; n++) begin : g_port
      logic                valid_q, valid_d;
      logic [BITS-1:0]     data_q,  data_d;
      logic [CNT_BITS-1:0] cnt_q,   cnt_d;
      logic                w_load;
      logic                w_take;

      assign w_load = in_valid & in_ready & w_port_sel[n];
      assign w_take = valid_q & w_out_ready[n];

      always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        if (w_load) begin
          valid_d = 1'b1;
          data_d  = in_data;
        end else if (w_take) begin
          valid_d = 1'b0;
        end
        if (w_take) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          valid_q <= 1'b0;
          data_q  <= '0;
          cnt_q   <= '0;
        end else begin
          valid_q <= valid_d;
          data_q  <= data_d;
          cnt_q   <= cnt_d;
        end
      end

      assign w_valid[n] = valid_q;
      assign w_data[n]  = data_q;
      assign w_cnt[n]   = cnt_q;
    end
  endgenerate

  assign out0_valid = w_valid[0];
  assign out1_valid = w_valid[1];
  assign out0_data  = w_data[0];
  assign out1_data  = w_data[1];
  assign cnt0       = w_cnt[0];
  assign cnt1       = w_cnt[1];

endmodule

`default_nettype wire

// File: doc/demux1_2.md
# demux1_2

Registered 1-to-2 demultiplexer with valid/ready handshakes, the steering counterpart of the 2:1 select mux in the 16-bit MIPS datapath. It accepts one BITS-wide word per handshake and routes it to output port 0 or 1 according to `sel`. Each output has its own one-entry holding register, so a stalled consumer never blocks traffic bound for the other port. Per-port wrapping transfer counters support debug and verification.

## Interface
- `BITS`, default 13: data width of input and both outputs.
- `CNT_BITS`, default 8: width of each per-port transfer counter.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous reset, active-low. Sampled on the rising edge of `clk`.
- `in_valid` input 1: upstream word present.
- `in_ready` output 1: block accepts the word this cycle.
- `sel` input 1: destination port (0 → port 0, 1 → port 1). Sampled only when `in_valid` is high.
- `in_data` input BITS: word to route.
- `out0_valid` output 1: port 0 holding register full.
- `out0_ready` input 1: port 0 consumer accepts.
- `out0_data` output BITS: port 0 word.
- `out1_valid` output 1: port 1 holding register full.
- `out1_ready` input 1: port 1 consumer accepts.
- `out1_data` output BITS: port 1 word.
- `cnt0` output CNT_BITS: completed port 0 output handshakes, modulo 2^CNT_BITS.
- `cnt1` output CNT_BITS: completed port 1 output handshakes, modulo 2^CNT_BITS.

## Operation
- Each port is a two-state slot: EMPTY (`outN_valid`=0) or FULL (`outN_valid`=1).
- Port N is free when `!outN_valid || outN_ready`.
- `in_ready` = free(port selected by `sel`), and is forced to 0 while `rst_n`=0. It is combinational from `sel`, `outN_valid` and `outN_ready`.
- Input handshake occurs when `in_valid && in_ready`. `in_data` is loaded into the selected slot and that slot becomes FULL.
- Output handshake on port N occurs when `outN_valid && outN_ready`.
- Slot transitions:
  - EMPTY → FULL on a load.
  - FULL → EMPTY on an output handshake with no load in the same cycle.
  - FULL → FULL with new data when an output handshake and a load happen in the same cycle (pass-through at full rate).
  - FULL holds its data unchanged while `outN_ready`=0.
- The unselected port is never written. Its slot state depends only on its own `outN_ready`.
- `outN_data` is stable whenever `outN_valid`=1 and `outN_ready`=0.
- `cntN` increments by 1 on each port N output handshake and wraps from 2^CNT_BITS−1 to 0. Input handshakes do not count.
- Word order within a port is preserved. Order across ports is not defined.

## Timing
- Reset (`rst_n`=0 at a rising edge):
  - `out0_valid`, `out1_valid` = 0.
  - `out0_data`, `out1_data` = 0.
  - `cnt0`, `cnt1` = 0.
  - `in_ready` = 0 combinationally for the whole reset cycle.
- Reset mid-operation: words held in either slot are discarded without handshake, and counters clear. The first post-reset cycle starts with both slots EMPTY.
- Latency: a word accepted at edge k is presented on `outN_data` with `outN_valid`=1 immediately after edge k. It can complete its output handshake at edge k+1.
- Throughput: 1 word per cycle per port when the consumer holds `outN_ready`=1. The two ports fill independently, alternating `sel` each cycle is sustainable.
- Backpressure: when the selected slot is FULL and its `outN_ready`=0, `in_ready`=0. Upstream must hold `in_data` and `sel` stable until the handshake completes.
- `in_valid` with `in_ready`=0 changes no state.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `in_valid`=1 → `in_ready`=0, both valids 0, both data 0, counters 0. Release → `in_ready`=1.
- Steering: send 0x0AA with sel=0, then 0x155 with sel=1, both consumers ready → `out0_data`=0x0AA one cycle after the first accept, `out1_data`=0x155 after the second. `cnt0`=1, `cnt1`=1.
- Backpressure isolation: `out0_ready`=0, send 0x001 to port 0, then 0x002/0x003 to port 1 → port 0 holds 0x001. A second port-0 word sees `in_ready`=0. Port 1 delivers 0x002, 0x003 in order.
- Full-rate pass-through: `out1_ready`=1, send 0x000..0x00F to port 1 back-to-back → `in_ready` stays 1, 16 words arrive in order, `cnt1`=16.
- Counter wrap: with CNT_BITS=8, complete 257 port-0 handshakes → `cnt0`=1 and `cnt1` unchanged.
- Reset mid-operation: both slots FULL with consumers stalled, pulse `rst_n`=0 for one cycle → both valids 0 and counters 0. The held words are never delivered.
